// File: rtl/bcd_add_seq.sv
// Digit-serial 3-digit signed-magnitude BCD adder: result = (+/-a) + b, one digit per clock.
// Optional BCD_ADD_INPUT_CHECK_EN: invalid input digits abort to DONE with err set.
module bcd_add_seq #(
  parameter int DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a_ones,
  input  logic [3:0] a_tens,
  input  logic [3:0] a_huns,
  input  logic       a_negative,
  input  logic [3:0] b_ones,
  input  logic [3:0] b_tens,
  input  logic [3:0] b_huns,
  output logic [3:0] out_ones,
  output logic [3:0] out_tens,
  output logic [3:0] out_huns,
  output logic       out_thous,
  output logic       negative,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [2:0] {IDLE, ADD, SUB, NEG, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       cnt;
  logic             last;
  logic             stepping;
  logic [W-1:0]     a_sh, b_sh, r_sh;
  logic             cy;
  logic             is_add;
  logic             neg_q;
  logic [4:0]       step;
  logic             bad_in;
  logic             bad_q;

  function automatic logic [4:0] add_digit(input logic [3:0] x, input logic [3:0] y,
                                           input logic ci);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'b0, ci};
    if (s > 5'd9) add_digit = {1'b1, s[3:0] + 4'd6};
    else          add_digit = {1'b0, s[3:0]};
  endfunction

  // Returns {borrow_out, digit} for y - x - bi.
  function automatic logic [4:0] sub_digit(input logic [3:0] x, input logic [3:0] y,
                                           input logic bi);
    logic signed [5:0] d;
    d = $signed({2'b0, y}) - $signed({2'b0, x}) - $signed({5'b0, bi});
    if (d < 0) begin
      d = d + 6'sd10;
      sub_digit = {1'b1, d[3:0]};
    end else begin
      sub_digit = {1'b0, d[3:0]};
    end
  endfunction

`ifdef BCD_ADD_INPUT_CHECK_EN
  assign bad_in = (a_ones > 4'd9) || (a_tens > 4'd9) || (a_huns > 4'd9) ||
                  (b_ones > 4'd9) || (b_tens > 4'd9) || (b_huns > 4'd9);
`else
  assign bad_in = 1'b0;
`endif

  assign busy     = (state != IDLE);
  assign stepping = (state == ADD) || (state == SUB) || (state == NEG);
  assign last     = (cnt == 2'(DIGITS - 1));
  assign step     = (state == ADD) ? add_digit(a_sh[3:0], b_sh[3:0], cy)
                                   : sub_digit(a_sh[3:0], b_sh[3:0], cy);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = bad_in ? DONE : (a_negative ? SUB : ADD);
      ADD:  if (last) state_nxt = DONE;
      SUB:  if (last) state_nxt = step[4] ? NEG : DONE;
      NEG:  if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters: consume the low digit each step, result digits enter from the top.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        a_sh   <= {a_huns, a_tens, a_ones};
        b_sh   <= {b_huns, b_tens, b_ones};
        cy     <= 1'b0;
        is_add <= !a_negative;
        neg_q  <= 1'b0;
        bad_q  <= bad_in;
      end
      ADD, SUB, NEG: begin
        if (state == SUB && last && step[4]) begin
          // Ten's-complement result: rerun it as 0 - r to get the magnitude.
          a_sh  <= {step[3:0], r_sh[W-1:4]};
          b_sh  <= '0;
          cy    <= 1'b0;
          neg_q <= 1'b1;
        end else begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          r_sh <= {step[3:0], r_sh[W-1:4]};
          cy   <= step[4];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 2'd0;
      done      <= 1'b0;
      out_ones  <= 4'd0;
      out_tens  <= 4'd0;
      out_huns  <= 4'd0;
      out_thous <= 1'b0;
      negative  <= 1'b0;
    end else begin
      cnt  <= (stepping && !last) ? cnt + 2'd1 : 2'd0;
      done <= (state == DONE);
      if (state == DONE) begin
        out_ones  <= bad_q ? 4'd0 : r_sh[3:0];
        out_tens  <= bad_q ? 4'd0 : r_sh[7:4];
        out_huns  <= bad_q ? 4'd0 : r_sh[11:8];
        out_thous <= !bad_q && is_add && cy;
        negative  <= !bad_q && neg_q && (r_sh != '0);
      end
    end
  end

`ifdef BCD_ADD_INPUT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                          err <= 1'b0;
    else if (state == IDLE && start)  err <= 1'b0;
    else if (state == DONE)           err <= bad_q;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_add_seq.sv
// Self-checking bench for bcd_add_seq: directed handshake cases plus random and
// round-trip operands checked against an integer-arithmetic reference.
module tb_bcd_add_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a_ones = '0, a_tens = '0, a_huns = '0;
  logic       a_negative = 1'b0;
  logic [3:0] b_ones = '0, b_tens = '0, b_huns = '0;
  logic [3:0] out_ones, out_tens, out_huns;
  logic       out_thous, negative, busy, done, err;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_last;
  logic [11:0] obs_last;

  bcd_add_seq #(.DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_ones(a_ones), .a_tens(a_tens), .a_huns(a_huns), .a_negative(a_negative),
    .b_ones(b_ones), .b_tens(b_tens), .b_huns(b_huns),
    .out_ones(out_ones), .out_tens(out_tens), .out_huns(out_huns),
    .out_thous(out_thous), .negative(negative), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Launch one operation and check latency, handshake and result against the model.
  task automatic run_op(input logic [11:0] ad, input bit an, input logic [11:0] bd,
                        input bit poke);
    int av, bv, res, mag, exp_lat, n;
    bit bad, got;
    logic [11:0] exp_d;
    bit exp_t, exp_n;
    bad = (ad[3:0] > 9) || (ad[7:4] > 9) || (ad[11:8] > 9) ||
          (bd[3:0] > 9) || (bd[7:4] > 9) || (bd[11:8] > 9);
    av  = ad[11:8] * 100 + ad[7:4] * 10 + ad[3:0];
    bv  = bd[11:8] * 100 + bd[7:4] * 10 + bd[3:0];
    res = (an ? -av : av) + bv;
    mag = (res < 0) ? -res : res;
    exp_d = bad ? 12'h000 : to_bcd(mag % 1000);
    exp_t = !bad && (mag >= 1000);
    exp_n = !bad && (res < 0);
    exp_lat = bad ? 1 : ((an && av > bv) ? 7 : 4);

    {a_huns, a_tens, a_ones} = ad;
    a_negative = an;
    {b_huns, b_tens, b_ones} = bd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_capture", busy, 1);
    // Operands must already be latched; scramble the inputs.
    {a_huns, a_tens, a_ones} = 12'($urandom);
    a_negative = 1'($urandom);
    {b_huns, b_tens, b_ones} = 12'($urandom);

    n = 0;
    got = 0;
    while (!got && n < 20) begin
      if (poke && n == 1) start = 1'b1;
      @(posedge clk); #1;
      n++;
      if (poke && n == 2) start = 1'b0;
      if (done) got = 1;
    end
    chk("latency", n, exp_lat);
    chk("busy_at_done", busy, 0);
    obs_last = {out_huns, out_tens, out_ones};
    exp_last = exp_d;
    chk("digits", obs_last, exp_d);
    chk("thous", out_thous, exp_t);
    chk("negative", negative, exp_n);
    chk("err", err, bad);
  endtask

  initial begin
    int a, b, cnt_done, diff;
    logic [11:0] ad, bd;

    // Reset state
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_digits", {out_huns, out_tens, out_ones}, 0);
    chk("rst_thous", out_thous, 0);
    chk("rst_negative", negative, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // Directed arithmetic
    run_op(12'h123, 0, 12'h456, 0); idle(1);
    run_op(12'h999, 0, 12'h999, 0); idle(1);
    run_op(12'h123, 1, 12'h456, 0); idle(1);
    run_op(12'h000, 1, 12'h000, 0); idle(1);
    run_op(12'h456, 1, 12'h123, 0); idle(1);
    run_op(12'h999, 1, 12'h000, 0); idle(1);
    chk("done_one_cycle", done, 0);

    // start while busy is ignored; outputs hold afterwards
    run_op(12'h123, 0, 12'h456, 1);
    cnt_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
    end
    chk("poke_extra_done", cnt_done, 0);
    chk("poke_busy", busy, 0);
    chk("hold_digits", {out_huns, out_tens, out_ones}, 12'h579);

    // Back-to-back: second start issued in the done cycle
    run_op(12'h250, 1, 12'h100, 0);
    run_op(12'h500, 0, 12'h501, 0);
    idle(2);

    // Reset mid-SUB aborts without a done pulse
    a_negative = 1'b1;
    {a_huns, a_tens, a_ones} = 12'h456;
    {b_huns, b_tens, b_ones} = 12'h123;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_digits", {out_huns, out_tens, out_ones}, 0);
    cnt_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
    end
    chk("abort_no_done", cnt_done, 0);

`ifdef BCD_ADD_INPUT_CHECK_EN
    run_op(12'h12C, 0, 12'h456, 0);
    idle(3);
    chk("err_held", err, 1);
    run_op(12'h111, 0, 12'h222, 0);
    idle(1);
`endif

    // Random operands
    for (int i = 0; i < 60; i++) begin
      ad = to_bcd($urandom_range(0, 999));
      bd = to_bcd($urandom_range(0, 999));
      run_op(ad, 1'($urandom), bd, 0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    // Round-trip through the subtractor's (|a-b|, a<b) output
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 999);
      b = $urandom_range(0, 999);
      diff = (a >= b) ? a - b : b - a;
      run_op(to_bcd(diff), (a < b), to_bcd(b), 0);
      chk("roundtrip", obs_last, to_bcd(a));
      idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
